// File: rtl/axilite_gpio_slave_if.sv
// AXI-Lite bus bundle for the GPIO slave: master drives requests, slave drives responses.
interface axilite_gpio_slave_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axilite_gpio_slave.sv
// AXI-Lite GPIO slave: OUT / IN / IRQ_EN / IRQ_STAT registers, rising-edge interrupts on the
// synchronized inputs, independent write and read channel FSMs.
module axilite_gpio_slave #(
   parameter int unsigned NUM_GPIO   = 1,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                clock_i,
   input  logic                reset_i,
   axilite_gpio_slave_if.slave s_axilite,
   input  logic [NUM_GPIO-1:0] gpio_in_i,
   output logic [NUM_GPIO-1:0] gpio_out_o,
   output logic                irq_o
);
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [1:0] REG_OUT      = 2'd0;
   localparam logic [1:0] REG_IN       = 2'd1;
   localparam logic [1:0] REG_IRQ_EN   = 2'd2;
   localparam logic [1:0] REG_IRQ_STAT = 2'd3;

   typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_e;
   typedef enum logic {R_IDLE, R_DATA} r_state_e;

   w_state_e w_state_q, w_state_d;
   r_state_e r_state_q, r_state_d;

   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
   logic [1:0]            bresp_q, bresp_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic [NUM_GPIO-1:0] out_q, out_d;
   logic [NUM_GPIO-1:0] en_q, en_d;
   logic [NUM_GPIO-1:0] stat_q, stat_d;
   logic [NUM_GPIO-1:0] sync1_q, sync2_q, prev_q;
   logic                irq_q, irq_d;

   logic aw_ready, w_ready, b_valid, ar_ready, r_valid;

   // Write event: asserted on the cycle both address and data are in hand
   logic                  do_write;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [STRB_WIDTH-1:0] wr_strb;

   logic [DATA_WIDTH-1:0] wr_mask, out_ext, en_ext, merged_out, merged_en, rd_word;
   logic [NUM_GPIO-1:0]   w1c, rise;

   // Write channel FSM: next state, capture of early AW/W, write event and response code
   always_comb begin
      w_state_d = w_state_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bresp_d   = bresp_q;
      aw_ready  = 1'b0;
      w_ready   = 1'b0;
      b_valid   = 1'b0;
      do_write  = 1'b0;
      wr_addr   = awaddr_q;
      wr_data   = wdata_q;
      wr_strb   = wstrb_q;
      unique case (w_state_q)
         W_IDLE: begin
            aw_ready = 1'b1;
            w_ready  = 1'b1;
            if (s_axilite.awvalid && s_axilite.wvalid) begin
               do_write  = 1'b1;
               wr_addr   = s_axilite.awaddr;
               wr_data   = s_axilite.wdata;
               wr_strb   = s_axilite.wstrb;
               w_state_d = W_RESP;
            end else if (s_axilite.awvalid) begin
               awaddr_d  = s_axilite.awaddr;
               w_state_d = W_HAVE_AW;
            end else if (s_axilite.wvalid) begin
               wdata_d   = s_axilite.wdata;
               wstrb_d   = s_axilite.wstrb;
               w_state_d = W_HAVE_W;
            end
         end
         W_HAVE_AW: begin
            w_ready = 1'b1;
            if (s_axilite.wvalid) begin
               do_write  = 1'b1;
               wr_data   = s_axilite.wdata;
               wr_strb   = s_axilite.wstrb;
               w_state_d = W_RESP;
            end
         end
         W_HAVE_W: begin
            aw_ready = 1'b1;
            if (s_axilite.awvalid) begin
               do_write  = 1'b1;
               wr_addr   = s_axilite.awaddr;
               w_state_d = W_RESP;
            end
         end
         W_RESP: begin
            b_valid = 1'b1;
            if (s_axilite.bready) begin
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
      if (do_write) begin
         bresp_d = (wr_addr[3:2] == REG_IN) ? RESP_SLVERR : RESP_OKAY;
      end
   end

   // Register next state: strobed OUT/IRQ_EN updates, W1C with edge-set priority, irq level
   always_comb begin
      wr_mask = '0;
      for (int i = 0; i < STRB_WIDTH; i++) begin
         wr_mask[8*i +: 8] = {8{wr_strb[i]}};
      end
      out_ext                 = '0;
      out_ext[NUM_GPIO-1:0]   = out_q;
      en_ext                  = '0;
      en_ext[NUM_GPIO-1:0]    = en_q;
      merged_out = (out_ext & ~wr_mask) | (wr_data & wr_mask);
      merged_en  = (en_ext & ~wr_mask) | (wr_data & wr_mask);
      out_d = out_q;
      en_d  = en_q;
      w1c   = '0;
      if (do_write) begin
         case (wr_addr[3:2])
            REG_OUT:      out_d = merged_out[NUM_GPIO-1:0];
            REG_IRQ_EN:   en_d  = merged_en[NUM_GPIO-1:0];
            REG_IRQ_STAT: w1c   = wr_data[NUM_GPIO-1:0];
            default:      ;
         endcase
      end
      rise   = sync2_q & ~prev_q;
      stat_d = (stat_q & ~w1c) | rise;
      irq_d  = |(stat_q & en_q);
   end

   // Read data mux on current register values, so a same-cycle write is not yet visible
   always_comb begin
      rd_word = '0;
      case (s_axilite.araddr[3:2])
         REG_OUT:    rd_word[NUM_GPIO-1:0] = out_q;
         REG_IN:     rd_word[NUM_GPIO-1:0] = sync2_q;
         REG_IRQ_EN: rd_word[NUM_GPIO-1:0] = en_q;
         default:    rd_word[NUM_GPIO-1:0] = stat_q;
      endcase
   end

   // Read channel FSM: capture data on AR handshake, hold until accepted
   always_comb begin
      r_state_d = r_state_q;
      rdata_d   = rdata_q;
      ar_ready  = 1'b0;
      r_valid   = 1'b0;
      unique case (r_state_q)
         R_IDLE: begin
            ar_ready = 1'b1;
            if (s_axilite.arvalid) begin
               rdata_d   = rd_word;
               r_state_d = R_DATA;
            end
         end
         R_DATA: begin
            r_valid = 1'b1;
            if (s_axilite.rready) begin
               r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // Write channel state and captured AW/W fields
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         w_state_q <= W_IDLE;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bresp_q   <= RESP_OKAY;
      end else begin
         w_state_q <= w_state_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bresp_q   <= bresp_d;
      end
   end

   // Read channel state and held read data
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_state_q <= R_IDLE;
         rdata_q   <= '0;
      end else begin
         r_state_q <= r_state_d;
         rdata_q   <= rdata_d;
      end
   end

   // GPIO registers, input synchronizer, edge history and interrupt output
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         out_q   <= '0;
         en_q    <= '0;
         stat_q  <= '0;
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         irq_q   <= 1'b0;
      end else begin
         out_q   <= out_d;
         en_q    <= en_d;
         stat_q  <= stat_d;
         sync1_q <= gpio_in_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         irq_q   <= irq_d;
      end
   end

   assign s_axilite.awready = aw_ready;
   assign s_axilite.wready  = w_ready;
   assign s_axilite.bvalid  = b_valid;
   assign s_axilite.bresp   = bresp_q;
   assign s_axilite.arready = ar_ready;
   assign s_axilite.rvalid  = r_valid;
   assign s_axilite.rdata   = rdata_q;
   assign s_axilite.rresp   = RESP_OKAY;

   assign gpio_out_o = out_q;
   assign irq_o      = irq_q;

   // Only address bits [3:2] decode; bits above NUM_GPIO are dropped
   logic unused_bits;
   assign unused_bits = ^{wr_addr, s_axilite.araddr, merged_out, merged_en, wr_data};
endmodule

// File: tb/tb_axilite_gpio_slave.sv
// Directed bench for axilite_gpio_slave (NUM_GPIO = 8): table of write/readback vectors plus
// hand-timed sequences for handshake ordering, interrupts, read backpressure and reset.
module tb_axilite_gpio_slave;
   logic       clock;
   logic       reset;
   logic [7:0] gpio_in;
   logic [7:0] gpio_out;
   logic       irq;

   int n_cmp = 0;
   int n_bad = 0;

   axilite_gpio_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   axilite_gpio_slave #(
      .NUM_GPIO  (8),
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32)
   ) dut (
      .clock_i   (clock),
      .reset_i   (reset),
      .s_axilite (bus),
      .gpio_in_i (gpio_in),
      .gpio_out_o(gpio_out),
      .irq_o     (irq)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  bresp;
      logic [31:0] rd_addr;
      logic [31:0] rdata;
      logic [7:0]  out;
   } vec_t;

   vec_t vecs[12];

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // AW and W presented together, bready held high
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
      int n;
      bus.awaddr  = addr;
      bus.awvalid = 1'b1;
      bus.wdata   = data;
      bus.wstrb   = strb;
      bus.wvalid  = 1'b1;
      bus.bready  = 1'b1;
      n = 0;
      while (!(bus.awready && bus.wready) && n < 20) begin
         step();
         n++;
      end
      step();
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      n = 0;
      while (!bus.bvalid && n < 20) begin
         step();
         n++;
      end
      check("wr_bvalid", 32'(bus.bvalid), 32'd1);
      resp = bus.bresp;
      step();
      bus.bready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
      int n;
      bus.araddr  = addr;
      bus.arvalid = 1'b1;
      bus.rready  = 1'b1;
      n = 0;
      while (!bus.arready && n < 20) begin
         step();
         n++;
      end
      step();
      bus.arvalid = 1'b0;
      n = 0;
      while (!bus.rvalid && n < 20) begin
         step();
         n++;
      end
      check("rd_rvalid", 32'(bus.rvalid), 32'd1);
      check("rd_rresp", 32'(bus.rresp), 32'd0);
      data = bus.rdata;
      step();
      bus.rready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0]  resp;
      logic [31:0] rd;

      // addr, data, strb, bresp, read addr, read data, gpio_out after write
      vecs[0]  = '{32'h0000_0000, 32'h0000_0001, 4'hF, 2'b00, 32'h0, 32'h01, 8'h01};
      vecs[1]  = '{32'h0000_0000, 32'h0000_00A5, 4'h0, 2'b00, 32'h0, 32'h01, 8'h01};
      vecs[2]  = '{32'h0000_0000, 32'hFFFF_FF5A, 4'h1, 2'b00, 32'h0, 32'h5A, 8'h5A};
      vecs[3]  = '{32'h0000_0000, 32'h0000_FF00, 4'h2, 2'b00, 32'h0, 32'h5A, 8'h5A};
      vecs[4]  = '{32'h0000_0010, 32'h0000_003C, 4'hF, 2'b00, 32'h0, 32'h3C, 8'h3C};
      vecs[5]  = '{32'h0000_0008, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h8, 32'hFF, 8'h3C};
      vecs[6]  = '{32'h0000_0008, 32'h0000_0000, 4'hE, 2'b00, 32'h8, 32'hFF, 8'h3C};
      vecs[7]  = '{32'h0000_0008, 32'h0000_0000, 4'h1, 2'b00, 32'h8, 32'h00, 8'h3C};
      vecs[8]  = '{32'h0000_0004, 32'h0000_00FF, 4'hF, 2'b10, 32'h4, 32'h00, 8'h3C};
      vecs[9]  = '{32'h0000_000C, 32'h0000_00FF, 4'hF, 2'b00, 32'hC, 32'h00, 8'h3C};
      vecs[10] = '{32'hFFFF_FFF8, 32'h0000_0081, 4'hF, 2'b00, 32'h8, 32'h81, 8'h3C};
      vecs[11] = '{32'h0000_0004, 32'h0000_003C, 4'h1, 2'b10, 32'h0, 32'h3C, 8'h3C};

      reset       = 1'b1;
      gpio_in     = 8'h00;
      bus.awaddr  = '0;
      bus.awvalid = 1'b0;
      bus.wdata   = '0;
      bus.wstrb   = '0;
      bus.wvalid  = 1'b0;
      bus.bready  = 1'b0;
      bus.araddr  = '0;
      bus.arvalid = 1'b0;
      bus.rready  = 1'b0;
      step();
      step();
      reset = 1'b0;

      // Reset state
      check("rst_awready", 32'(bus.awready), 32'd1);
      check("rst_wready", 32'(bus.wready), 32'd1);
      check("rst_arready", 32'(bus.arready), 32'd1);
      check("rst_bvalid", 32'(bus.bvalid), 32'd0);
      check("rst_rvalid", 32'(bus.rvalid), 32'd0);
      check("rst_bresp", 32'(bus.bresp), 32'd0);
      check("rst_rresp", 32'(bus.rresp), 32'd0);
      check("rst_rdata", bus.rdata, 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_gpio_out", 32'(gpio_out), 32'd0);

      // AW and W in the same cycle: bvalid and gpio_out one cycle later
      bus.awaddr  = 32'h0;
      bus.wdata   = 32'h1;
      bus.wstrb   = 4'hF;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      bus.bready  = 1'b0;
      step();
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      check("same_cyc_bvalid", 32'(bus.bvalid), 32'd1);
      check("same_cyc_bresp", 32'(bus.bresp), 32'd0);
      check("same_cyc_gpio_out", 32'(gpio_out), 32'd1);
      bus.bready = 1'b1;
      step();
      bus.bready = 1'b0;
      check("same_cyc_bvalid_drop", 32'(bus.bvalid), 32'd0);

      // Write/readback vectors
      for (int i = 0; i < 12; i++) begin
         axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
         check($sformatf("vec%0d_bresp", i), 32'(resp), 32'(vecs[i].bresp));
         check($sformatf("vec%0d_gpio_out", i), 32'(gpio_out), 32'(vecs[i].out));
         axi_read(vecs[i].rd_addr, rd);
         check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
      end

      // W two cycles ahead of AW, bready low for 3 cycles
      bus.wdata  = 32'h1;
      bus.wstrb  = 4'hF;
      bus.wvalid = 1'b1;
      bus.bready = 1'b0;
      step();
      bus.wvalid = 1'b0;
      check("w_first_awready", 32'(bus.awready), 32'd1);
      check("w_first_wready", 32'(bus.wready), 32'd0);
      check("w_first_bvalid", 32'(bus.bvalid), 32'd0);
      step();
      bus.awaddr  = 32'h8;
      bus.awvalid = 1'b1;
      step();
      bus.awvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("bhold%0d_bvalid", i), 32'(bus.bvalid), 32'd1);
         check($sformatf("bhold%0d_bresp", i), 32'(bus.bresp), 32'd0);
         step();
      end
      bus.bready = 1'b1;
      check("bhold3_bvalid", 32'(bus.bvalid), 32'd1);
      step();
      bus.bready = 1'b0;
      check("bhold_release", 32'(bus.bvalid), 32'd0);
      axi_read(32'h8, rd);
      check("irq_en_after_w_first", rd, 32'h1);

      // Rising edge -> IRQ_STAT -> irq_o, then W1C
      gpio_in = 8'h01;
      step();
      step();
      step();
      check("irq_latency_low", 32'(irq), 32'd0);
      step();
      check("irq_latency_high", 32'(irq), 32'd1);
      axi_read(32'hC, rd);
      check("irq_stat_set", rd, 32'h1);
      bus.awaddr  = 32'hC;
      bus.wdata   = 32'h1;
      bus.wstrb   = 4'hF;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      bus.bready  = 1'b1;
      step();
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      check("w1c_bvalid", 32'(bus.bvalid), 32'd1);
      check("w1c_irq_still_high", 32'(irq), 32'd1);
      step();
      bus.bready = 1'b0;
      check("w1c_irq_low", 32'(irq), 32'd0);

      // Edge coincident with W1C of the same bit: set wins
      gpio_in = 8'h00;
      repeat (4) step();
      gpio_in = 8'h01;
      repeat (4) step();
      check("pre_coinc_irq", 32'(irq), 32'd1);
      gpio_in = 8'h00;
      repeat (4) step();
      gpio_in = 8'h01;
      step();
      step();
      bus.awaddr  = 32'hC;
      bus.wdata   = 32'h1;
      bus.wstrb   = 4'hF;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      bus.bready  = 1'b1;
      step();
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      check("coinc_bvalid", 32'(bus.bvalid), 32'd1);
      step();
      bus.bready = 1'b0;
      check("coinc_irq", 32'(irq), 32'd1);
      axi_read(32'hC, rd);
      check("coinc_stat", rd, 32'h1);

      // Write to IN is rejected; read with rready held low
      axi_write(32'h4, 32'hFF, 4'hF, resp);
      check("in_write_bresp", 32'(resp), 32'd2);
      bus.araddr  = 32'h4;
      bus.arvalid = 1'b1;
      bus.rready  = 1'b0;
      step();
      bus.arvalid = 1'b0;
      gpio_in     = 8'hF0;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("rhold%0d_rvalid", i), 32'(bus.rvalid), 32'd1);
         check($sformatf("rhold%0d_rdata", i), bus.rdata, 32'h01);
         check($sformatf("rhold%0d_rresp", i), 32'(bus.rresp), 32'd0);
         step();
      end
      bus.rready = 1'b1;
      check("rhold2_rdata", bus.rdata, 32'h01);
      step();
      bus.rready = 1'b0;
      check("rhold_release", 32'(bus.rvalid), 32'd0);
      axi_read(32'h4, rd);
      check("in_follows_pins", rd, 32'hF0);

      // Reset while holding an AW with no W
      axi_write(32'h0, 32'h77, 4'hF, resp);
      check("pre_rst_gpio_out", 32'(gpio_out), 32'h77);
      gpio_in     = 8'h00;
      bus.awaddr  = 32'h0;
      bus.awvalid = 1'b1;
      bus.bready  = 1'b1;
      step();
      bus.awvalid = 1'b0;
      check("have_aw_awready", 32'(bus.awready), 32'd0);
      check("have_aw_wready", 32'(bus.wready), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("post_rst_awready", 32'(bus.awready), 32'd1);
      check("post_rst_wready", 32'(bus.wready), 32'd1);
      check("post_rst_gpio_out", 32'(gpio_out), 32'd0);
      check("post_rst_irq", 32'(irq), 32'd0);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("post_rst_bvalid%0d", i), 32'(bus.bvalid), 32'd0);
         step();
      end
      bus.bready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         axi_read(32'(i * 4), rd);
         check($sformatf("post_rst_reg%0d", i), rd, 32'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
